mod_exp_seq: RTL and testbench
==============================

# mod_exp_seq

Sequential modular-exponentiation engine for the RSA datapath: computes `result = base^exp mod n` by MSB-first square-and-multiply. It consumes the remainder of every double-width product through a bit-serial restoring reducer, one remainder bit per cycle. It sits directly downstream of the operand registers and feeds the encrypt/decrypt result register. Operation is constant-sequence: every exponent bit is scanned and no leading zeros are skipped.

## Interface
- `ARQ`, 16, operand width in bits (base, exponent, modulus, result)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; accepted only when `busy`=0
- `base`  in  ARQ  message/cipher word, sampled on accept
- `exp`  in  ARQ  exponent, sampled on accept
- `n`  in  ARQ  modulus, sampled on accept
- `busy`  out  1  high from cycle after accept until `done` cycle inclusive
- `done`  out  1  one-cycle pulse, result valid
- `result`  out  ARQ  final remainder, held until next accept
- `err`  out  1  modulus-error flag, valid with `done` (see Configuration)

## Operation
- Clock and reset are fixed: one clock (`clk`); `rst` is synchronous and active-high.
- States:
  - `IDLE`: accept `start`; latch operands into `B`, `E`, `N`.
  - `LOAD`: 1 cycle. `acc`=1. Product register `P` = zero-extended `B`.
  - `RED_BASE`: reduce `P` mod `N`, then store `B`=`P mod N`.
  - `SQ`: `P`=`acc*acc`.
  - `MUL`: entered only if current `E` bit (MSB-first) is 1. `P`=`acc*B`.
  - `DONE`: `done`=1; `result`=`acc`.
- Transitions:
  - Each of `SQ` and `MUL` occupies 1 product cycle plus 2·ARQ reduction cycles. After reduction, `acc` = remainder.
  - After `MUL`, or after `SQ` with a 0 bit, shift `E` left. Decrement the bit counter (ARQ→0).
  - Counter 0 → `DONE` → `IDLE`.
- Arithmetic:
  - Product is 2·ARQ bits, unsigned. Reducer remainder is ARQ+1 bits.
  - Restoring step per cycle: shift-in next dividend MSB, subtract `N`, restore if negative (sign bit ARQ).
  - All values are unsigned. Remainder is always < `N` for `N`≥1.
- Boundary cases:
  - `exp`=0 → result = 1 mod n (0 when n=1).
  - `base`≥`n` is legal; it is reduced first.
  - `n`=1 → result 0.
- `start` while `busy`: ignored; it does not queue.
- Input changes after accept have no effect.
- Reset mid-operation: next cycle is `IDLE`. All outputs and the reducer are cleared.
- Reset values: `busy`=0, `done`=0, `result`=0, `err`=0.

## Timing
- `start` sampled high in `IDLE` at edge k.
- `busy` rises at k+1.
- Define T = 2·ARQ+1 cycles.
- `done` high in cycle k+L, where L = 2 + T·(1 + ARQ + popcount(exp)).
- ARQ=16: T=33; popcount 0 → L=563.
- `busy` falls the cycle after `done`. A new `start` is accepted in that cycle (back-to-back period L+1).
- `result` and `err` update in the `done` cycle. They are stable until the next `done`.

## Configuration
- Macro: `MODEXP_ZERO_MOD_CHECK_EN`.
- Defined:
  - `n`=0 at accept → skip `LOAD`/reduction.
  - `done` at k+2 with `err`=1 and `result`=0.
  - Otherwise `err`=0.
- Undefined:
  - `err` is tied 0.
  - `n`=0 runs full latency L and terminates without hang. `result` value is unspecified.

## Structure
- Shared package `rsa_pkg`:
  - ARQ default
  - state enum (`IDLE`, `LOAD`, `RED_BASE`, `SQ`, `MUL`, `DONE`)
  - localparam T
- Sub-module `mod_reduce_serial`:
  - inputs: 2·ARQ-bit dividend, ARQ-bit divisor
  - handshake: `go`/`fin`
  - 2·ARQ cycles, one quotient bit per cycle, remainder output
  - same `clk`/`rst`
- Instantiate exactly once. `mod_exp_seq` shares it across base reduction, square, and multiply.

## Test plan
- base=4, exp=13, n=497 → result=445, err=0, `done` exactly 662 cycles after accept.
- base=5, exp=3, n=13 → result=8 at L=629. Then immediately base=7, exp=0, n=11 in the cycle after `done` → result=1 at L=563.
- base=600, exp=1, n=97 → result=18 (base ≥ n reduced first). base=9, exp=5, n=1 → result=0.
- `start` pulsed mid-run with different operands → ignored; first result unchanged. Assert `rst` at cycle 100 of a run → `busy`/`done`/`result` 0 next cycle, then a fresh run is correct.
- n=0: with `MODEXP_ZERO_MOD_CHECK_EN`, `done`@k+2 with err=1, result=0. Without it, `done`@k+L with err=0 and no hang.

Source files
------------

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared width, reduction-phase length and state encoding for the RSA exponentiation datapath
package rsa_pkg;
    localparam int ARQ = 16;
    localparam int T = 2 * ARQ + 1;
    typedef enum logic [2:0] {IDLE, LOAD, RED_BASE, SQ, MUL, DONE} state_e;
endpackage

// File: rtl/mod_exp_seq_reduce.sv
// mod_reduce_serial: restoring bit-serial remainder of a 2W-bit dividend by a W-bit divisor, one bit per cycle
module mod_reduce_serial
    import rsa_pkg::*;
#(
    parameter int W = ARQ
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           go,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           fin,
    output logic [W-1:0]   rem
);
    localparam int CW = $clog2(2 * W + 1);
    logic [2*W-1:0] d;
    logic [W-1:0] r, dv;
    logic [CW-1:0] cnt;
    logic [W:0] t, diff;
    logic neg;
    // One restoring step: bring down the next dividend bit, trial-subtract, restore on a negative result
    always_comb begin
        t = {r, d[2*W-1]};
        diff = t - {1'b0, dv};
        neg = diff[W];
        rem = neg ? t[W-1:0] : diff[W-1:0];
        fin = cnt == CW'(1);
    end
    // Load on go, then step each cycle; quotient bits refill the vacated dividend LSBs
    always_ff @(posedge clk) begin
        if (rst) begin
            d <= '0;
            r <= '0;
            dv <= '0;
            cnt <= '0;
        end else if (go) begin
            d <= dividend;
            dv <= divisor;
            r <= '0;
            cnt <= CW'(2 * W);
        end else if (cnt != '0) begin
            d <= {d[2*W-2:0], ~neg};
            r <= rem;
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/mod_exp_seq.sv
// mod_exp_seq: constant-sequence MSB-first square-and-multiply base^exp mod n; optional MODEXP_ZERO_MOD_CHECK_EN flags n=0
module mod_exp_seq
    import rsa_pkg::*;
#(
    parameter int ARQ = rsa_pkg::ARQ
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [ARQ-1:0] base,
    input  logic [ARQ-1:0] exp,
    input  logic [ARQ-1:0] n,
    output logic           busy,
    output logic           done,
    output logic [ARQ-1:0] result,
    output logic           err
);
    localparam int CW = $clog2(ARQ + 1);
    state_e st;
    logic run, go, fin, last;
    logic [ARQ-1:0] b, e, nn, acc, rem, res;
    logic [CW-1:0] cnt;
    logic [2*ARQ-1:0] p, ax, bx;
`ifdef MODEXP_ZERO_MOD_CHECK_EN
    logic zm, err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
    assign busy = st != IDLE;
    assign done = st == DONE;
    assign result = res;
    // Single reducer serves base reduction, squaring and multiplication; go fires on the first cycle of each phase
    always_comb begin
        ax = {{ARQ{1'b0}}, acc};
        bx = {{ARQ{1'b0}}, b};
        p = st == RED_BASE ? bx : st == SQ ? ax * ax : ax * bx;
        go = (st == RED_BASE || st == SQ || st == MUL) && !run;
        last = cnt == CW'(1);
    end
    mod_reduce_serial #(.W(ARQ)) u_red (
        .clk(clk),
        .rst(rst),
        .go(go),
        .dividend(p),
        .divisor(nn),
        .fin(fin),
        .rem(rem)
    );
    // Sequencer: every exponent bit costs one square, set bits add a multiply
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            run <= 1'b0;
            b <= '0;
            e <= '0;
            nn <= '0;
            acc <= '0;
            res <= '0;
            cnt <= '0;
`ifdef MODEXP_ZERO_MOD_CHECK_EN
            zm <= 1'b0;
            err_q <= 1'b0;
`endif
        end else begin
            case (st)
                IDLE: if (start) begin
                    b <= base;
                    e <= exp;
                    nn <= n;
                    cnt <= CW'(ARQ);
                    st <= LOAD;
`ifdef MODEXP_ZERO_MOD_CHECK_EN
                    zm <= n == '0;
`endif
                end
                LOAD: begin
                    acc <= ARQ'(1);
                    st <= RED_BASE;
`ifdef MODEXP_ZERO_MOD_CHECK_EN
                    if (zm) begin
                        st <= DONE;
                        res <= '0;
                        err_q <= 1'b1;
                    end
`endif
                end
                DONE: st <= IDLE;
                default: begin
                    if (go) run <= 1'b1;
                    else if (fin) begin
                        run <= 1'b0;
                        if (st == RED_BASE) begin
                            b <= rem;
                            st <= SQ;
                        end else begin
                            acc <= rem;
                            if (st == SQ && e[ARQ-1]) st <= MUL;
                            else begin
                                e <= e << 1;
                                cnt <= cnt - 1'b1;
                                st <= last ? DONE : SQ;
                                if (last) begin
                                    res <= rem;
`ifdef MODEXP_ZERO_MOD_CHECK_EN
                                    err_q <= 1'b0;
`endif
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mod_exp_seq.sv
// tb_mod_exp_seq: scoreboard bench for mod_exp_seq (latency, result, err, reset, ignored start, back-to-back)
module tb_mod_exp_seq;
    localparam int W = 16;
    localparam int TT = 2 * W + 1;
    typedef struct {
        logic [W-1:0] res;
        logic err;
        int lat;
        bit chk_res;
    } exp_t;
    logic clk = 1'b0, rst, start;
    logic [W-1:0] base, exp, n, result;
    logic busy, done, err;
    int checks = 0, failures = 0;
    exp_t sb[$];
    mod_exp_seq dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .exp(exp), .n(n),
        .busy(busy), .done(done), .result(result), .err(err)
    );
    always #5 clk = ~clk;
    function automatic logic [W-1:0] model(logic [W-1:0] b, logic [W-1:0] e, logic [W-1:0] m);
        longint r, bb;
        if (m == 0) return '0;
        r = 1 % longint'(m);
        bb = longint'(b) % longint'(m);
        for (int i = W - 1; i >= 0; i--) begin
            r = (r * r) % longint'(m);
            if (e[i]) r = (r * bb) % longint'(m);
        end
        return W'(r);
    endfunction
    function automatic int lat_of(logic [W-1:0] e, logic [W-1:0] m);
`ifdef MODEXP_ZERO_MOD_CHECK_EN
        if (m == 0) return 2;
`endif
        return 2 + TT * (1 + W + $countones(e));
    endfunction
    task automatic issue(logic [W-1:0] b, logic [W-1:0] e, logic [W-1:0] m);
        exp_t x;
        for (int i = 0; i < 2000 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        x.res = model(b, e, m);
        x.lat = lat_of(e, m);
`ifdef MODEXP_ZERO_MOD_CHECK_EN
        x.err = m == 0;
        x.chk_res = 1'b1;
`else
        x.err = 1'b0;
        x.chk_res = m != 0;
`endif
        sb.push_back(x);
        base = b;
        exp = e;
        n = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!done && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        base = '0;
        exp = '0;
        n = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, err, result} !== {3'b000, 16'h0}) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b err=%b result=%0d expected all 0", busy, done, err, result);
        end
    endtask
    task automatic test_single(string name, logic [W-1:0] b, logic [W-1:0] e, logic [W-1:0] m);
        int lat;
        exp_t x;
        issue(b, e, m);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy: got %b expected 1", name, busy);
        end
        wait_done(1, lat);
        x = sb.pop_front();
        checks++;
        if (lat !== x.lat) begin
            failures++;
            $display("FAIL %s_lat: got %0d expected %0d", name, lat, x.lat);
        end
        checks++;
        if (err !== x.err) begin
            failures++;
            $display("FAIL %s_err: got %b expected %b", name, err, x.err);
        end
        if (x.chk_res) begin
            checks++;
            if (result !== x.res) begin
                failures++;
                $display("FAIL %s_result: got %0d expected %0d", name, result, x.res);
            end
        end
    endtask
    task automatic test_back_to_back();
        int lat;
        exp_t x;
        issue(5, 3, 13);
        wait_done(1, lat);
        x = sb.pop_front();
        checks++;
        if (lat !== x.lat || result !== x.res) begin
            failures++;
            $display("FAIL b2b_first: lat=%0d result=%0d expected lat=%0d result=%0d", lat, result, x.lat, x.res);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: busy=%b expected 0", busy);
        end
        issue(7, 0, 11);
        wait_done(1, lat);
        x = sb.pop_front();
        checks++;
        if (lat !== x.lat || result !== x.res || err !== x.err) begin
            failures++;
            $display("FAIL b2b_second: lat=%0d result=%0d err=%b expected lat=%0d result=%0d err=%b", lat, result, err, x.lat, x.res, x.err);
        end
    endtask
    task automatic test_start_ignored();
        int lat;
        exp_t x;
        issue(4, 13, 497);
        repeat (50) @(posedge clk);
        #1;
        base = 3;
        exp = 7;
        n = 101;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        base = 1;
        n = 2;
        wait_done(52, lat);
        x = sb.pop_front();
        checks++;
        if (lat !== x.lat || result !== x.res) begin
            failures++;
            $display("FAIL ignore_start: lat=%0d result=%0d expected lat=%0d result=%0d", lat, result, x.lat, x.res);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || result !== x.res) begin
            failures++;
            $display("FAIL no_queue: busy=%b result=%0d expected busy=0 result=%0d", busy, result, x.res);
        end
    endtask
    task automatic test_mid_reset();
        exp_t x;
        issue(9, 16'hffff, 1000);
        repeat (98) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        x = sb.pop_front();
        checks++;
        if ({busy, done, err, result} !== {3'b000, 16'h0}) begin
            failures++;
            $display("FAIL mid_reset: busy=%b done=%b err=%b result=%0d expected all 0 (dropped %0d)", busy, done, err, result, x.res);
        end
        test_single("after_reset", 4, 13, 497);
    endtask
    initial begin
        test_reset();
        test_single("basic", 4, 13, 497);
        test_back_to_back();
        test_single("base_ge_n", 600, 1, 97);
        test_single("n_one", 9, 5, 1);
        test_single("wide", 16'hfffe, 16'hbeef, 16'hfff1);
        test_start_ignored();
        test_mid_reset();
        test_single("zero_mod", 5, 3, 0);
        test_single("post_zero", 2, 10, 1000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
